// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI responder defaults, byte-enable width helper and throttle LFSR constants
package obi_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 39;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  function automatic int be_bits(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/obi_resp_lfsr.sv
// obi_resp_lfsr: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11); ports clk_i, rst_i (sync seed load), en_i (advance), lsb_o (state bit 0)
module obi_resp_lfsr import obi_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic lsb_o
);
  logic [15:0] state;
  always_ff @(posedge clk_i)
    if (rst_i) state <= SEED;
    else if (en_i) state <= {^(state & LFSR_TAPS), state[15:1]};
  assign lsb_o = state[0];
endmodule

// File: rtl/obi_sram_responder.sv
// obi_sram_responder: OBI responder onto a single-port sync SRAM; ports: OBI req/gnt/rvalid/rdata, hold_i back-pressure, SRAM ce/we/wmask/addr/wdata/rdata, oor_cnt_o out-of-range counter
module obi_sram_responder import obi_pkg::*; #(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DEPTH     = 512,
  parameter int          SRAM_LAT  = 1,
  parameter bit          GNT_THROT = 1'b0,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  localparam int         BE_BITS   = be_bits(DATA_W),
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [BE_BITS-1:0] be_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [DATA_W-1:0]  rdata_o,
  input  logic               hold_i,
  output logic               sram_ce_o,
  output logic               sram_we_o,
  output logic [BE_BITS-1:0] sram_wmask_o,
  output logic [IDX_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]  sram_wdata_o,
  input  logic [DATA_W-1:0]  sram_rdata_i,
  output logic [15:0]        oor_cnt_o
);
  localparam int OFF = $clog2(BE_BITS);
  logic lfsr_lsb, acc, rd, oor;
  logic [SRAM_LAT-1:0] vld, oorp;
  obi_resp_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (req_i & ~gnt_o),
    .lsb_o (lfsr_lsb)
  );
  always_comb begin
    gnt_o        = req_i & ~hold_i & ~rst_i & (GNT_THROT ? ~lfsr_lsb : 1'b1);
    acc          = req_i & gnt_o;
    rd           = acc & ~we_i;
    oor          = |(addr_i >> (OFF + IDX_W));
    sram_ce_o    = acc & ~oor;
    sram_we_o    = sram_ce_o & we_i;
    sram_wmask_o = sram_we_o ? be_i : '0;
    sram_addr_o  = sram_ce_o ? addr_i[OFF +: IDX_W] : '0;
    sram_wdata_o = sram_we_o ? wdata_i : '0;
    rvalid_o     = vld[SRAM_LAT-1] & ~rst_i;
    rdata_o      = (rvalid_o & ~oorp[SRAM_LAT-1]) ? sram_rdata_i : '0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      vld       <= '0;
      oorp      <= '0;
      oor_cnt_o <= '0;
    end else begin
      vld  <= (vld << 1) | SRAM_LAT'(rd);
      oorp <= (oorp << 1) | SRAM_LAT'(rd & oor);
      if (acc && oor && oor_cnt_o != 16'hFFFF) oor_cnt_o <= oor_cnt_o + 16'd1;
    end
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      a_rvalid_known: assert (!$isunknown(rvalid_o));
      a_hold_no_gnt: assert (!(hold_i && gnt_o));
    end
endmodule

// File: tb/tb_obi_sram_responder.sv
// tb_obi_sram_responder: directed and random checks of four responder configurations against behavioural SRAMs
module tb_obi_sram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, we, hold;
  logic [7:0] be;
  logic [38:0] addr;
  logic [63:0] wdata;
  int sel;
  int total = 0;
  int bad = 0;
  logic rq[4], gnt[4], rvalid[4], ce[4], swe[4];
  logic [7:0] wmask[4];
  logic [8:0] saddr[4];
  logic [63:0] swdata[4], srdata[4], rdata[4];
  logic [15:0] oor[4];
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam bit TH = (g == 3);
    logic [63:0] mem [512];
    logic [63:0] pipe [LAT];
    assign rq[g] = req && (sel == g);
    obi_sram_responder #(.DATA_W(64), .ADDR_W(39), .DEPTH(512), .SRAM_LAT(LAT), .GNT_THROT(TH)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(rq[g]), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt[g]), .rvalid_o(rvalid[g]), .rdata_o(rdata[g]), .hold_i(hold),
      .sram_ce_o(ce[g]), .sram_we_o(swe[g]), .sram_wmask_o(wmask[g]), .sram_addr_o(saddr[g]),
      .sram_wdata_o(swdata[g]), .sram_rdata_i(srdata[g]), .oor_cnt_o(oor[g]));
    always @(posedge clk) begin
      if (ce[g] && swe[g])
        for (int b = 0; b < 8; b++) if (wmask[g][b]) mem[saddr[g]][8*b +: 8] <= swdata[g][8*b +: 8];
      pipe[0] <= (ce[g] && !swe[g]) ? mem[saddr[g]] : 64'h0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign srdata[g] = pipe[LAT-1];
  end
  logic [63:0] ref_mem [16];
  logic [63:0] q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input int k, input bit r, input bit w, input logic [7:0] b, input logic [38:0] a, input logic [63:0] d);
    sel = k; req = r; we = w; be = b; addr = a; wdata = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mstep(output bit a);
    logic [63:0] e, m;
    bit o;
    @(negedge clk);
    if (hold) chk("hold_gnt", gnt[3], 0);
    if (rvalid[3]) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL dup_rvalid got=1 exp=0");
      end else begin
        e = q.pop_front();
        chk("rand_rdata", rdata[3], e);
      end
    end
    a = req && gnt[3];
    o = |addr[38:7];
    if (a && !we) q.push_back(o ? 64'h0 : ref_mem[addr[6:3]]);
    if (a && we && !o) begin
      m = ref_mem[addr[6:3]];
      for (int b = 0; b < 8; b++) if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[addr[6:3]] = m;
    end
    tick();
  endtask
  task automatic do_op(input bit w, input logic [7:0] b, input logic [38:0] a, input logic [63:0] d);
    bit acc = 1'b0;
    int tries = 0;
    drv(3, 1, w, b, a, d);
    while (!acc && tries < 64) begin
      hold = ($urandom_range(0, 4) == 0);
      mstep(acc);
      tries++;
    end
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL gnt_timeout got=0 exp=1");
    end
    req = 1'b0;
    hold = 1'b0;
  endtask
  initial begin
    bit dummy;
    logic [38:0] a;
    rst = 1'b1; hold = 1'b0;
    drv(0, 1, 0, 8'hFF, 39'h40, 64'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", gnt[0], 0);
      chk("rst_rvalid", rvalid[0], 0);
      chk("rst_ce", ce[0], 0);
      tick();
    end
    chk("rst_oor", oor[0], 0);
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    rst = 1'b0;
    tick();
    drv(0, 1, 1, 8'hFF, 39'h40, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    chk("wr_gnt", gnt[0], 1);
    chk("wr_ce", ce[0], 1);
    chk("wr_we", swe[0], 1);
    chk("wr_addr", saddr[0], 9'd8);
    chk("wr_mask", wmask[0], 8'hFF);
    tick();
    drv(0, 1, 0, 8'h00, 39'h40, 64'h0);
    @(negedge clk);
    chk("rd_gnt", gnt[0], 1);
    chk("rd_ce", ce[0], 1);
    chk("rd_we", swe[0], 0);
    chk("wr_no_rvalid", rvalid[0], 0);
    tick();
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("rd_rvalid", rvalid[0], 1);
    chk("rd_data", rdata[0], 64'hDEADBEEF_CAFEF00D);
    tick();
    @(negedge clk);
    chk("rd_rvalid_pulse", rvalid[0], 0);
    chk("rd_data_idle", rdata[0], 64'h0);
    tick();
    drv(0, 1, 1, 8'hFF, 39'h48, 64'hFFFFFFFF_FFFFFFFF);
    tick();
    drv(0, 1, 1, 8'h0F, 39'h48, 64'h11223344_55667788);
    @(negedge clk);
    chk("pw_mask", wmask[0], 8'h0F);
    tick();
    drv(0, 1, 0, 8'h00, 39'h4D, 64'h0);
    tick();
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("pw_rvalid", rvalid[0], 1);
    chk("pw_data", rdata[0], 64'hFFFFFFFF_55667788);
    tick();
    drv(0, 1, 0, 8'hFF, 39'h40, 64'h0);
    hold = 1'b1;
    @(negedge clk);
    chk("hold_gnt0", gnt[0], 0);
    chk("hold_ce0", ce[0], 0);
    tick();
    hold = 1'b0;
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("hold_no_rvalid", rvalid[0], 0);
    tick();
    drv(0, 1, 0, 8'hFF, 39'h1 << 20, 64'h0);
    @(negedge clk);
    chk("oor_gnt", gnt[0], 1);
    chk("oor_ce", ce[0], 0);
    tick();
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("oor_rvalid", rvalid[0], 1);
    chk("oor_data", rdata[0], 64'h0);
    chk("oor_cnt1", oor[0], 16'd1);
    tick();
    drv(0, 1, 1, 8'hFF, 39'h1040, 64'h12345678_9ABCDEF0);
    @(negedge clk);
    chk("oorw_ce", ce[0], 0);
    tick();
    drv(0, 1, 0, 8'h00, 39'h40, 64'h0);
    @(negedge clk);
    chk("oor_cnt2", oor[0], 16'd2);
    tick();
    drv(0, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("oorw_dropped", rdata[0], 64'hDEADBEEF_CAFEF00D);
    tick();
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, 1, 8'hFF, 39'h100 + 39'(8 * i), 64'hA5A50000_00000000 | 64'(i * 32'h1111));
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drv(1, 1, 0, 8'h00, 39'h100 + 39'(8 * c), 64'h0);
      else drv(1, 0, 0, 8'h00, 39'h0, 64'h0);
      @(negedge clk);
      if (c < 8) chk("b2b_gnt", gnt[1], 1);
      chk("b2b_rvalid", rvalid[1], (c >= 3 && c < 11));
      chk("b2b_data", rdata[1], (c >= 3 && c < 11) ? (64'hA5A50000_00000000 | 64'((c - 3) * 32'h1111)) : 64'h0);
      tick();
    end
    drv(2, 1, 1, 8'hFF, 39'h80, 64'h0BADF00D_01234567);
    tick();
    drv(2, 1, 0, 8'h00, 39'h80, 64'h0);
    @(negedge clk);
    chk("mr_gnt", gnt[2], 1);
    tick();
    drv(2, 0, 0, 8'h00, 39'h0, 64'h0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mr_no_rvalid", rvalid[2], 0);
      tick();
      rst = 1'b0;
    end
    drv(2, 1, 0, 8'h00, 39'h80, 64'h0);
    tick();
    drv(2, 0, 0, 8'h00, 39'h0, 64'h0);
    @(negedge clk);
    chk("mr_lat_early", rvalid[2], 0);
    tick();
    @(negedge clk);
    chk("mr_rvalid", rvalid[2], 1);
    chk("mr_data_kept", rdata[2], 64'h0BADF00D_01234567);
    tick();
    for (int i = 0; i < 16; i++) do_op(1'b1, 8'hFF, 39'(8 * i), {$urandom, $urandom});
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 9) == 0) ? ((39'h1 << 20) | 39'($urandom_range(0, 127)))
                                      : 39'($urandom_range(0, 127));
      do_op(1'($urandom_range(0, 1)), 8'($urandom), a, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) mstep(dummy);
    end
    repeat (8) mstep(dummy);
    chk("lost_rvalid", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
